// File: rtl/forth_cpu_core_if.sv
// Bus and status bundle between the ForthCPU core and the system bus buffers.
// The core drives address, write data, strobes and phase status (master);
// the memory side returns read data (slave).
interface forth_cpu_core_if;
    logic        STOPPED;
    logic        FETCH;
    logic        DECODE;
    logic        EXECUTE;
    logic        COMMIT;
    logic [15:0] DIN_BUF;
    logic [15:0] DOUT_BUF;
    logic [15:0] ADDR_BUF;
    logic        WR0_BUF;
    logic        WR1_BUF;
    logic        RD_BUF;

    modport master (
        output STOPPED, FETCH, DECODE, EXECUTE, COMMIT,
        output DOUT_BUF, ADDR_BUF, WR0_BUF, WR1_BUF, RD_BUF,
        input  DIN_BUF
    );

    modport slave (
        input  STOPPED, FETCH, DECODE, EXECUTE, COMMIT,
        input  DOUT_BUF, ADDR_BUF, WR0_BUF, WR1_BUF, RD_BUF,
        output DIN_BUF
    );
endinterface

// File: rtl/forth_cpu_core.sv
// 16-bit multi-cycle ForthCPU core: ALU and load/store groups over a 16-bit byte-addressed bus.
// Latency: every instruction takes four clocks (FETCH, DECODE, EXECUTE, COMMIT); HALT stops the core.
// Backpressure: none; the bus is assumed to answer reads in the same cycle and accept writes at once.
module forth_cpu_core #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic CLK,
    input  logic RESET,
    forth_cpu_core_if.master bus
);

    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_DECODE  = 2'd1,
        PH_EXECUTE = 2'd2,
        PH_COMMIT  = 2'd3
    } phase_t;

    phase_t      r_phase;
    logic        r_stopped;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_regs [16];
    logic [15:0] r_opa;        // destination / store-data register value
    logic [15:0] r_opb;        // ALU source operand
    logic [15:0] r_maddr;      // memory address for the EXECUTE access
    logic [15:0] r_res;        // value to write back at COMMIT
    logic [3:0]  r_dst;
    logic        r_wen;
    logic [15:0] r_addr_last;  // bus address held between active cycles
    logic [15:0] r_dout_last;  // write data held between stores

    // Instruction field decode from the current IR
    logic [1:0]  w_grp;
    logic        w_is_alu;
    logic        w_is_lds;
    logic        w_is_halt;
    logic [3:0]  w_alu_op;
    logic [1:0]  w_alu_mode;
    logic        w_alu_imm;
    logic        w_lds_byte;
    logic [1:0]  w_lds_op;
    logic        w_lds_here;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_mem_op;
    logic [3:0]  w_dst;
    logic [15:0] w_src;
    logic [15:0] w_maddr;
    logic [15:0] w_alu_res;
    logic [15:0] w_ld_dat;
    logic [15:0] w_st_dat;
    logic        w_active;
    logic        w_exec;

    assign w_grp      = r_ir[15:14];
    assign w_is_alu   = (w_grp == 2'b01);
    assign w_is_lds   = (w_grp == 2'b10);
    assign w_is_halt  = (w_grp == 2'b00) && r_ir[13];
    assign w_alu_op   = r_ir[13:10];
    assign w_alu_mode = r_ir[9:8];
    assign w_alu_imm  = (w_alu_mode == 2'b01) || (w_alu_mode == 2'b10);
    assign w_lds_byte = r_ir[13];
    assign w_lds_op   = r_ir[12:11];
    assign w_lds_here = (r_ir[10:8] == 3'b001);
    assign w_is_ld    = w_is_lds && (w_lds_op == 2'b00);
    // A store in HERE mode is a NOP that only skips the literal word.
    assign w_is_st    = w_is_lds && (w_lds_op == 2'b01) && !w_lds_here;
    assign w_mem_op   = w_is_ld || w_is_st;
    assign w_dst      = (w_is_alu && w_alu_imm) ? 4'hA : r_ir[7:4];
    assign w_maddr    = (w_lds_here) ? (r_pc + 16'd2) : r_regs[r_ir[3:0]];

    // ALU source operand selection by addressing mode
    always_comb begin
        w_src = r_regs[r_ir[3:0]];
        case (w_alu_mode)
            2'b01:   w_src = {8'h00, r_ir[7:0]};
            2'b10:   w_src = {{8{r_ir[7]}}, r_ir[7:0]};
            default: w_src = r_regs[r_ir[3:0]];
        endcase
    end

    // ALU result from latched operands; shifts act on the destination value
    always_comb begin
        w_alu_res = r_opb;
        case (w_alu_op)
            4'd1:    w_alu_res = r_opa + r_opb;
            4'd2:    w_alu_res = r_opa - r_opb;
            4'd3:    w_alu_res = r_opa & r_opb;
            4'd4:    w_alu_res = r_opa | r_opb;
            4'd5:    w_alu_res = r_opa ^ r_opb;
            4'd6:    w_alu_res = {r_opa[14:0], 1'b0};
            4'd7:    w_alu_res = {1'b0, r_opa[15:1]};
            default: w_alu_res = r_opb;
        endcase
    end

    // Byte loads pick the lane addressed by bit 0; byte stores replicate onto both lanes
    assign w_ld_dat = !w_lds_byte ? bus.DIN_BUF :
                      (r_maddr[0] ? {8'h00, bus.DIN_BUF[15:8]} : {8'h00, bus.DIN_BUF[7:0]});
    assign w_st_dat = w_lds_byte ? {r_opa[7:0], r_opa[7:0]} : r_opa;

    // Strobes drop as soon as reset is asserted, not at the next clock
    assign w_active = !r_stopped && !RESET;
    assign w_exec   = (r_phase == PH_EXECUTE);

    assign bus.STOPPED  = r_stopped;
    assign bus.FETCH    = (r_phase == PH_FETCH)   && !r_stopped;
    assign bus.DECODE   = (r_phase == PH_DECODE)  && !r_stopped;
    assign bus.EXECUTE  = (r_phase == PH_EXECUTE) && !r_stopped;
    assign bus.COMMIT   = (r_phase == PH_COMMIT)  && !r_stopped;
    assign bus.RD_BUF   = w_active && ((r_phase == PH_FETCH) || (w_exec && w_is_ld));
    assign bus.WR0_BUF  = w_active && w_exec && w_is_st && (!w_lds_byte || !r_maddr[0]);
    assign bus.WR1_BUF  = w_active && w_exec && w_is_st && (!w_lds_byte ||  r_maddr[0]);
    assign bus.ADDR_BUF = RESET ? 16'h0000 :
                          (bus.FETCH)                     ? r_pc    :
                          (w_active && w_exec && w_mem_op) ? r_maddr : r_addr_last;
    assign bus.DOUT_BUF = RESET ? 16'h0000 :
                          (w_active && w_exec && w_is_st) ? w_st_dat : r_dout_last;

    // Phase sequencer with register file, operand latches and write-back
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_phase     <= PH_FETCH;
            r_stopped   <= 1'b0;
            r_pc        <= RESET_VECTOR;
            r_ir        <= 16'h0000;
            r_opa       <= 16'h0000;
            r_opb       <= 16'h0000;
            r_maddr     <= 16'h0000;
            r_res       <= 16'h0000;
            r_dst       <= 4'h0;
            r_wen       <= 1'b0;
            r_addr_last <= 16'h0000;
            r_dout_last <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (!r_stopped) begin
            case (r_phase)
                PH_FETCH: begin
                    r_ir        <= bus.DIN_BUF;
                    r_addr_last <= r_pc;
                    r_phase     <= PH_DECODE;
                end
                PH_DECODE: begin
                    r_opa   <= r_regs[w_dst];
                    r_opb   <= w_src;
                    r_maddr <= w_maddr;
                    r_dst   <= w_dst;
                    r_wen   <= w_is_alu || w_is_ld;
                    r_phase <= PH_EXECUTE;
                end
                PH_EXECUTE: begin
                    r_res <= w_is_ld ? w_ld_dat : w_alu_res;
                    if (w_mem_op) begin
                        r_addr_last <= r_maddr;
                    end
                    if (w_is_st) begin
                        r_dout_last <= w_st_dat;
                    end
                    r_phase <= PH_COMMIT;
                end
                PH_COMMIT: begin
                    if (r_wen) begin
                        r_regs[r_dst] <= r_res;
                    end
                    r_pc <= r_pc + ((w_is_lds && w_lds_here) ? 16'd4 : 16'd2);
                    if (w_is_halt) begin
                        r_stopped <= 1'b1;
                    end
                    r_phase <= PH_FETCH;
                end
                default: r_phase <= PH_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_forth_cpu_core.sv
// Self-checking bench for forth_cpu_core: directed programs plus a random program
// checked cycle by cycle against an instruction-level reference model.
module tb_forth_cpu_core;

    logic CLK = 1'b0;
    logic RESET;

    forth_cpu_core_if bus ();

    forth_cpu_core #(.RESET_VECTOR(16'h0000)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Bus-side memory, written only from observed DUT strobes
    logic [15:0] mem   [32768];
    // Reference model state
    logic [15:0] m_mem [32768];
    logic [15:0] m_regs [16];
    logic [15:0] m_pc;
    logic        m_halted;
    logic [15:0] m_last_addr;
    logic [15:0] m_last_dout;

    // Observed EXECUTE-cycle bus values of the last instruction
    logic [15:0] o_addr;
    logic [15:0] o_dout;
    logic [1:0]  o_wr;

    int n_cmp  = 0;
    int n_fail = 0;

    assign bus.DIN_BUF = mem[bus.ADDR_BUF[15:1]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, want);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] w);
        mem[a[15:1]]   = w;
        m_mem[a[15:1]] = w;
    endtask

    task automatic fill(input bit rnd);
        logic [15:0] w;
        for (int i = 0; i < 32768; i++) begin
            w = rnd ? 16'($urandom) : 16'h0000;
            mem[i]   = w;
            m_mem[i] = w;
        end
    endtask

    task automatic model_reset;
        m_pc        = 16'h0000;
        m_halted    = 1'b0;
        m_last_addr = 16'h0000;
        m_last_dout = 16'h0000;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    endtask

    // Reset and leave the bench sampling inside the first FETCH cycle
    task automatic do_reset;
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        chk("rst_stopped", bus.STOPPED, 16'd0);
        chk("rst_fetch",   bus.FETCH, 16'd1);
        chk("rst_strobes", {bus.RD_BUF, bus.WR1_BUF, bus.WR0_BUF}, 16'd0);
        chk("rst_addr",    bus.ADDR_BUF, 16'h0000);
        chk("rst_dout",    bus.DOUT_BUF, 16'h0000);
        RESET = 1'b0;
        #1;
    endtask

    // Run one instruction through the DUT while the model executes it at ISA level
    task automatic run_instr;
        logic [15:0] ir, ea, src, a, w, res, nxt, e_addr, e_dout;
        logic [3:0]  dst;
        bit          e_rd, e_wr0, e_wr1, wen, halt, mem_op, is_st, here;
        int          guard;
        guard = 0;
        while (bus.FETCH !== 1'b1 && guard < 6) begin
            @(negedge CLK);
            guard++;
        end
        chk("fetch_strobe",    bus.FETCH, 16'd1);
        chk("fetch_addr",      bus.ADDR_BUF, m_pc);
        chk("fetch_rd",        bus.RD_BUF, 16'd1);
        chk("fetch_wr",        {bus.WR1_BUF, bus.WR0_BUF}, 16'd0);
        chk("fetch_dout_hold", bus.DOUT_BUF, m_last_dout);

        ir = m_mem[m_pc[15:1]];
        e_rd = 0; e_wr0 = 0; e_wr1 = 0; wen = 0; halt = 0; mem_op = 0; is_st = 0;
        e_addr = m_pc; e_dout = m_last_dout; res = 16'h0000; dst = 4'h0;
        nxt = m_pc + 16'd2;
        case (ir[15:14])
            2'b00: halt = ir[13];
            2'b01: begin
                if (ir[9:8] == 2'b01) begin
                    dst = 4'hA; src = {8'h00, ir[7:0]};
                end else if (ir[9:8] == 2'b10) begin
                    dst = 4'hA; src = 16'($signed(ir[7:0]));
                end else begin
                    dst = ir[7:4]; src = m_regs[ir[3:0]];
                end
                a = m_regs[dst];
                case (ir[13:10])
                    4'd1:    res = a + src;
                    4'd2:    res = a - src;
                    4'd3:    res = a & src;
                    4'd4:    res = a | src;
                    4'd5:    res = a ^ src;
                    4'd6:    res = a * 16'd2;
                    4'd7:    res = a / 16'd2;
                    default: res = src;
                endcase
                wen = 1;
            end
            2'b10: begin
                here = (ir[10:8] == 3'b001);
                if (here) nxt = m_pc + 16'd4;
                if (ir[12:11] == 2'b00) begin
                    ea  = here ? m_pc + 16'd2 : m_regs[ir[3:0]];
                    w   = m_mem[ea[15:1]];
                    res = !ir[13] ? w : (ea[0] ? (w >> 8) : (w & 16'h00FF));
                    e_rd = 1; e_addr = ea; mem_op = 1; wen = 1; dst = ir[7:4];
                end else if (ir[12:11] == 2'b01 && !here) begin
                    ea = m_regs[ir[3:0]];
                    a  = m_regs[ir[7:4]];
                    mem_op = 1; is_st = 1; e_addr = ea;
                    if (ir[13]) begin
                        e_dout = {a[7:0], a[7:0]};
                        e_wr0 = !ea[0]; e_wr1 = ea[0];
                        if (ea[0]) m_mem[ea[15:1]][15:8] = a[7:0];
                        else       m_mem[ea[15:1]][7:0]  = a[7:0];
                    end else begin
                        e_dout = a; e_wr0 = 1; e_wr1 = 1;
                        m_mem[ea[15:1]] = a;
                    end
                end
            end
            default: ;
        endcase

        @(negedge CLK);
        chk("decode_strobe",    bus.DECODE, 16'd1);
        chk("decode_bus",       {bus.RD_BUF, bus.WR1_BUF, bus.WR0_BUF}, 16'd0);
        chk("decode_addr_hold", bus.ADDR_BUF, m_pc);

        @(negedge CLK);
        chk("exec_strobe", bus.EXECUTE, 16'd1);
        chk("exec_rd",     bus.RD_BUF, 16'(e_rd));
        chk("exec_wr0",    bus.WR0_BUF, 16'(e_wr0));
        chk("exec_wr1",    bus.WR1_BUF, 16'(e_wr1));
        chk("exec_addr",   bus.ADDR_BUF, e_addr);
        chk("exec_dout",   bus.DOUT_BUF, e_dout);
        o_addr = bus.ADDR_BUF;
        o_dout = bus.DOUT_BUF;
        o_wr   = {bus.WR1_BUF, bus.WR0_BUF};
        if (o_wr[0]) mem[o_addr[15:1]][7:0]  = o_dout[7:0];
        if (o_wr[1]) mem[o_addr[15:1]][15:8] = o_dout[15:8];
        m_last_addr = mem_op ? e_addr : m_pc;
        if (is_st) m_last_dout = e_dout;

        @(negedge CLK);
        chk("commit_strobe",    bus.COMMIT, 16'd1);
        chk("commit_bus",       {bus.RD_BUF, bus.WR1_BUF, bus.WR0_BUF}, 16'd0);
        chk("commit_addr_hold", bus.ADDR_BUF, m_last_addr);
        if (wen) m_regs[dst] = res;
        m_pc = nxt;
        if (halt) m_halted = 1'b1;

        @(negedge CLK);
        chk("stopped", bus.STOPPED, 16'(m_halted));
        if (m_halted) begin
            chk("stopped_phases", {bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT}, 16'd0);
            chk("stopped_bus",    {bus.RD_BUF, bus.WR1_BUF, bus.WR0_BUF}, 16'd0);
            chk("stopped_addr",   bus.ADDR_BUF, m_last_addr);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        logic [2:0]  md;
        r  = 16'($urandom);
        md = ($urandom_range(0, 3) == 0) ? r[10:8] : {2'b00, r[8]};
        case ($urandom_range(0, 9))
            0:       return {3'b000, r[12:0]};
            1:       return {2'b11, r[13:0]};
            2, 3, 4: return {2'b01, r[13:0]};
            5, 6:    return {2'b10, r[13], 2'b00, md, r[7:0]};
            7, 8:    return {2'b10, r[13], 2'b01, md, r[7:0]};
            default: return {2'b10, r[13], 1'b1, r[11:0]};
        endcase
    endfunction

    initial begin
        logic [15:0] pa;
        logic [15:0] di;
        int          steps;

        RESET = 1'b1;

        // NOP stream from an all-zero memory
        fill(1'b0);
        do_reset();
        repeat (3) run_instr();

        // Directed program: load literal, word/byte stores, ADD, HALT
        fill(1'b0);
        put(16'h0000, 16'h8100);
        put(16'h0002, 16'hFAAF);
        put(16'h0004, 16'h42AF);
        put(16'h0006, 16'h88A0);
        put(16'h0008, 16'h41FA);
        put(16'h000A, 16'h88A0);
        put(16'h000C, 16'hA8A0);
        put(16'h000E, 16'h44A0);
        put(16'h0010, 16'h88A0);
        put(16'h0012, 16'h2000);
        do_reset();
        run_instr();
        chk("ldhere_addr", o_addr, 16'h0002);
        chk("ldhere_next_pc", bus.ADDR_BUF, 16'h0004);
        run_instr();
        run_instr();
        chk("st_s8_addr", o_addr, 16'hFAAF);
        chk("st_s8_dout", o_dout, 16'hFFAF);
        chk("st_s8_wr",   16'(o_wr), 16'd3);
        run_instr();
        run_instr();
        chk("st_u8_dout", o_dout, 16'h00FA);
        chk("st_u8_wr",   16'(o_wr), 16'd3);
        run_instr();
        chk("stb_dout", o_dout, 16'hFAFA);
        chk("stb_wr",   16'(o_wr), 16'd2);
        pa = 16'hFAAF;
        chk("stb_mem",  mem[pa[15:1]], 16'hFAFA);
        run_instr();
        run_instr();
        chk("add_result", o_dout, 16'hFBA9);
        run_instr();
        repeat (3) @(negedge CLK);
        chk("halt_held", {bus.STOPPED, bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT}, 16'h0010);

        // Reset asserted during the EXECUTE cycle of a word store
        fill(1'b0);
        put(16'h0000, 16'h41FA);
        put(16'h0002, 16'h88A0);
        do_reset();
        run_instr();
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_rst_wr", {bus.WR1_BUF, bus.WR0_BUF}, 16'd3);
        RESET = 1'b1;
        #1;
        chk("midrst_strobes", {bus.RD_BUF, bus.WR1_BUF, bus.WR0_BUF}, 16'd0);
        chk("midrst_addr",    bus.ADDR_BUF, 16'h0000);
        chk("midrst_stopped", bus.STOPPED, 16'd0);
        chk("midrst_fetch",   bus.FETCH, 16'd1);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midrst_restart", bus.ADDR_BUF, 16'h0000);
        run_instr();
        run_instr();
        chk("midrst_rerun", o_dout, 16'h00FA);

        // Random program, then dump every register through ST Ri,[R1], then HALT
        fill(1'b1);
        pa = 16'h0000;
        for (int i = 0; i < 48; i++) begin
            put(pa, rand_instr());
            pa = pa + 16'd2;
        end
        for (int i = 0; i < 16; i++) begin
            di = 16'h8801 | 16'(i << 4);
            put(pa, di);
            pa = pa + 16'd2;
        end
        put(pa, 16'h2000);
        do_reset();
        steps = 0;
        while (!m_halted && steps < 200) begin
            run_instr();
            steps++;
        end
        chk("rand_stopped", bus.STOPPED, 16'(m_halted));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
